// File: rtl/shift_add_ctrl.sv
// shift_add_ctrl: control sequencer for a shift-and-add multiplier.
// Issues load/add/shift strobes for N iterations and then a one-cycle done pulse.
// Optional feature macro: SHIFT_ADD_CYCLE_CNT_EN adds the last_cycles output,
// which reports the length of the most recent operation in cycles.
// All outputs are registers loaded from the next-state decode, so each output
// changes on the same edge as the state register and depends only on state.
module shift_add_ctrl #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          q0,
    output logic          load,
    output logic          add,
    output logic          shift,
    output logic          busy,
    output logic          ready,
    output logic          done,
`ifdef SHIFT_ADD_CYCLE_CNT_EN
    output logic [7:0]    last_cycles,
`endif
    output logic [CW-1:0] count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_TEST  = 3'd2;
    localparam logic [2:0] ST_ADD   = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          armed_r;
    logic          armed_nxt_s;

    // Next-state, iteration-count and start-arming logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = count_r;
        // A low start in any state re-arms the launch; only an armed rising start is accepted.
        if (!start) begin
            armed_nxt_s = 1'b1;
        end else begin
            armed_nxt_s = armed_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start && armed_r) begin
                    state_nxt_s = ST_LOAD;
                    armed_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = CW'(N);
                state_nxt_s = ST_TEST;
            end
            ST_TEST: begin
                if (q0) begin
                    state_nxt_s = ST_ADD;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_ADD: begin
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (count_r == CW'(1)) begin
                    count_nxt_s = count_r - CW'(1);
                    state_nxt_s = ST_DONE;
                end else if (count_r == '0) begin
                    // Unreachable in normal operation; refuse to wrap and fall back to idle.
                    count_nxt_s = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    count_nxt_s = count_r - CW'(1);
                    state_nxt_s = ST_TEST;
                end
            end
            ST_DONE: begin
                count_nxt_s = '0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                count_nxt_s = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, arming flag and registered Moore outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            armed_r <= 1'b0;
            load    <= 1'b0;
            add     <= 1'b0;
            shift   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            armed_r <= armed_nxt_s;
            load    <= (state_nxt_s == ST_LOAD);
            add     <= (state_nxt_s == ST_ADD);
            shift   <= (state_nxt_s == ST_SHIFT);
            done    <= (state_nxt_s == ST_DONE);
            busy    <= (state_nxt_s != ST_IDLE);
            ready   <= (state_nxt_s == ST_IDLE);
        end
    end

    assign count = count_r;

`ifdef SHIFT_ADD_CYCLE_CNT_EN
    logic [7:0] cyc_cnt_r;
    logic [7:0] last_cycles_r;

    // Increment that sticks at the top of the 8-bit range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // Operation length counter; the LOAD cycle counts as cycle one, DONE is the last cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt_r     <= 8'd0;
            last_cycles_r <= 8'd0;
        end else begin
            case (state_r)
                ST_LOAD:  cyc_cnt_r <= 8'd1;
                ST_TEST,
                ST_ADD,
                ST_SHIFT: cyc_cnt_r <= sat_inc8(cyc_cnt_r);
                ST_DONE:  last_cycles_r <= sat_inc8(cyc_cnt_r);
                default:  cyc_cnt_r <= cyc_cnt_r;
            endcase
        end
    end

    assign last_cycles = last_cycles_r;
`endif

endmodule

// File: tb/tb_shift_add_ctrl.sv
// tb_shift_add_ctrl: self-checking bench for shift_add_ctrl with a datapath model.
// Expected strobe traces, counts and products come from the multiplier bits directly.
module tb_shift_add_ctrl;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          q0;
    logic          load;
    logic          add;
    logic          shift;
    logic          busy;
    logic          ready;
    logic          done;
    logic [CW-1:0] count;
`ifdef SHIFT_ADD_CYCLE_CNT_EN
    logic [7:0]    last_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Datapath model: A, Q, C, M plus the operands to load.
    logic [N-1:0] dp_a;
    logic [N-1:0] dp_q;
    logic [N-1:0] dp_m;
    logic         dp_c;
    logic [N-1:0] opa_m;
    logic [N-1:0] opa_q;

    always #5 clock = ~clock;

    shift_add_ctrl #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .q0          (q0),
        .load        (load),
        .add         (add),
        .shift       (shift),
        .busy        (busy),
        .ready       (ready),
        .done        (done),
`ifdef SHIFT_ADD_CYCLE_CNT_EN
        .last_cycles (last_cycles),
`endif
        .count       (count)
    );

    assign q0 = dp_q[0];

    // Datapath registers reacting to the controller strobes.
    always @(posedge clock) begin
        if (load) begin
            dp_a <= '0;
            dp_c <= 1'b0;
            dp_q <= opa_q;
            dp_m <= opa_m;
        end else if (add) begin
            {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
        end else if (shift) begin
            {dp_c, dp_a, dp_q} <= {1'b0, dp_c, dp_a, dp_q[N-1:1]};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready_busy"}, 32'({ready, busy}), 32'(2'b10));
        check_eq({tag, "_strobes"}, 32'({load, add, shift, done}), 32'(4'b0000));
        check_eq({tag, "_count"}, 32'(count), 32'(0));
    endtask

    // One multiply: arm, raise start, then compare every cycle against the expected trace.
    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                          input bit hold, input int abort_at);
        logic [3:0] exp_strb[$];
        int         exp_cnt[$];
        int         total;
        int         prod;
        total = 2 + 2 * N + $countones(q);
        prod  = int'(m) * int'(q);
        exp_strb.push_back(4'b1000); exp_cnt.push_back(0);
        for (int i = 0; i < N; i++) begin
            exp_strb.push_back(4'b0000); exp_cnt.push_back(N - i);
            if (q[i]) begin
                exp_strb.push_back(4'b0100); exp_cnt.push_back(N - i);
            end
            exp_strb.push_back(4'b0010); exp_cnt.push_back(N - i);
        end
        exp_strb.push_back(4'b0001); exp_cnt.push_back(0);

        @(posedge clock); #1;
        opa_m = m;
        opa_q = q;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = hold;
        for (int c = 1; c <= total; c++) begin
            @(negedge clock);
            check_eq("strobes", 32'({load, add, shift, done}), 32'(exp_strb[c-1]));
            check_eq("ready_busy", 32'({ready, busy}), 32'(2'b01));
            check_eq("count", 32'(count), 32'(exp_cnt[c-1]));
            if (c == total) begin
                check_eq("product", 32'({dp_a, dp_q}), 32'(prod));
            end
            if (c == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                @(negedge clock);
                check_idle("abort");
`ifdef SHIFT_ADD_CYCLE_CNT_EN
                check_eq("last_cycles_reset", 32'(last_cycles), 32'(0));
`endif
                return;
            end
        end
        @(negedge clock);
        check_idle("post_op");
`ifdef SHIFT_ADD_CYCLE_CNT_EN
        check_eq("last_cycles", 32'(last_cycles), 32'((total > 255) ? 255 : total));
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opa_m = '0;
        opa_q = '0;
        dp_a  = '0;
        dp_q  = '0;
        dp_m  = '0;
        dp_c  = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_idle("reset_idle");
        end
`ifdef SHIFT_ADD_CYCLE_CNT_EN
        check_eq("last_cycles_init", 32'(last_cycles), 32'(0));
`endif

        // Directed operands: 5*7, 5*0, 5*15.
        run_op(4'b0101, 4'b0111, 1'b0, 0);
        run_op(4'b0101, 4'b0000, 1'b0, 0);
        run_op(4'b0101, 4'b1111, 1'b0, 0);

        // Start held high: one operation only, then nothing until start drops.
        run_op(4'b0011, 4'b0101, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_idle("held_start");
        end
        run_op(4'b0110, 4'b1001, 1'b0, 0);

        // Reset during the ADD of the second iteration (cycle 6 for multiplier 0111).
        run_op(4'b0101, 4'b0111, 1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_idle("after_abort");
        end
        run_op(4'b0101, 4'b0111, 1'b0, 0);

        // Randomized operands.
        for (int i = 0; i < 20; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
